// File: rtl/avl_bus_arbiter_pkg.sv
// Shared types, bus widths and helpers for the Avalon bus arbiter slice.
package avl_bus_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } avl_arb_state_t;

  localparam int AVL_ARB_ID_W        = 4;
  localparam int AVL_ADDR_W          = 32;
  localparam int AVL_DATA_W          = 32;
  localparam int AVL_BE_W            = AVL_DATA_W / 8;
  localparam int ALV_BURST_MAX_COUNT = 15;
  localparam int AVL_BURST_W         = $clog2(ALV_BURST_MAX_COUNT + 1);

  // Next master ID after id, wrapping at num.
  function automatic logic [AVL_ARB_ID_W-1:0] avl_arb_next_id(
    input logic [AVL_ARB_ID_W-1:0] id,
    input int                      num
  );
    int n;
    n = int'(id) + 1;
    if (n >= num) n = 0;
    return AVL_ARB_ID_W'(n);
  endfunction

endpackage

// File: rtl/avl_bus_id_fifo.sv
// Synchronous FIFO holding the master ID of every outstanding read beat.
module avl_bus_id_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_dout    = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
        r_wr_ptr                   <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/avl_bus_arbiter.sv
// Burst-locking arbiter sharing one Avalon slave among MASTER_NUM masters.
// Define AVL_ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module avl_bus_arbiter
  import avl_bus_arbiter_pkg::*;
#(
  parameter int MASTER_NUM      = 4,
  parameter int RESP_FIFO_DEPTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rest,
  input  logic [MASTER_NUM-1:0][AVL_ADDR_W-1:0]  i_s_address,
  input  logic [MASTER_NUM-1:0][AVL_BE_W-1:0]    i_s_byte_en,
  input  logic [MASTER_NUM-1:0]                  i_s_read,
  input  logic [MASTER_NUM-1:0]                  i_s_write,
  input  logic [MASTER_NUM-1:0][AVL_DATA_W-1:0]  i_s_write_data,
  input  logic [MASTER_NUM-1:0]                  i_s_begin_burst_transfer,
  input  logic [MASTER_NUM-1:0][AVL_BURST_W-1:0] i_s_burst_count,
  output logic [MASTER_NUM-1:0]                  o_s_request_ready,
  output logic [AVL_DATA_W-1:0]                  o_s_read_data,
  output logic [MASTER_NUM-1:0]                  o_s_read_data_valid,
  input  logic [MASTER_NUM-1:0]                  i_s_resp_ready,
  output logic [AVL_ADDR_W-1:0]                  o_m_address,
  output logic [AVL_BE_W-1:0]                    o_m_byte_en,
  output logic                                   o_m_read,
  output logic                                   o_m_write,
  output logic [AVL_DATA_W-1:0]                  o_m_write_data,
  output logic                                   o_m_begin_burst_transfer,
  output logic [AVL_BURST_W-1:0]                 o_m_burst_count,
  input  logic                                   i_m_request_ready,
  input  logic [AVL_DATA_W-1:0]                  i_m_read_data,
  input  logic                                   i_m_read_data_valid,
  output logic                                   o_m_resp_ready,
  output logic                                   resp_err
);

  localparam int                     ID_W     = AVL_ARB_ID_W;
  localparam logic [AVL_BURST_W-1:0] BEAT_ONE = 1;

  avl_arb_state_t         r_state;
  avl_arb_state_t         w_state_next;
  logic [ID_W-1:0]        r_owner;
  logic [ID_W-1:0]        w_owner_next;
  logic [AVL_BURST_W-1:0] r_beats_left;
  logic [AVL_BURST_W-1:0] w_beats_next;
  logic                   r_resp_err;

  logic [MASTER_NUM-1:0]  w_req;
  logic [ID_W-1:0]        w_winner;
  logic                   w_winner_vld;
  logic [ID_W-1:0]        w_sel;
  logic                   w_fwd_en;
  logic                   w_grant_rdy;
  logic                   w_accept;
  logic                   w_burst_start;

  logic [AVL_ADDR_W-1:0]  w_sel_addr;
  logic [AVL_BE_W-1:0]    w_sel_be;
  logic                   w_sel_read;
  logic                   w_sel_write;
  logic [AVL_DATA_W-1:0]  w_sel_wdata;
  logic                   w_sel_begin;
  logic [AVL_BURST_W-1:0] w_sel_bcnt;

  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [ID_W-1:0]        w_head_id;
  logic                   w_head_rdy;

  assign w_req = i_s_read | i_s_write;

`ifdef AVL_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_rr_ptr;
  logic            w_txn_end;

  // Scan offsets from rr_ptr upward; the first requesting master wins.
  always_comb begin
    w_winner     = '0;
    w_winner_vld = 1'b0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      for (int m = 0; m < MASTER_NUM; m++) begin
        if (!w_winner_vld && w_req[m] &&
            (m == (int'(r_rr_ptr) + k) % MASTER_NUM)) begin
          w_winner     = ID_W'(m);
          w_winner_vld = 1'b1;
        end
      end
    end
  end

  assign w_txn_end = w_accept &&
                     (((r_state == ARB_IDLE) && !w_burst_start) ||
                      ((r_state == ARB_BURST) && (r_beats_left == BEAT_ONE)));

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_rr_ptr <= '0;
    end else if (w_txn_end) begin
      r_rr_ptr <= avl_arb_next_id(w_sel, MASTER_NUM);
    end
  end
`else
  always_comb begin
    w_winner     = '0;
    w_winner_vld = 1'b0;
    for (int m = MASTER_NUM - 1; m >= 0; m--) begin
      if (w_req[m]) begin
        w_winner     = ID_W'(m);
        w_winner_vld = 1'b1;
      end
    end
  end
`endif

  assign w_sel    = (r_state == ARB_BURST) ? r_owner : w_winner;
  assign w_fwd_en = !rest && ((r_state == ARB_BURST) || w_winner_vld);

  always_comb begin
    w_sel_addr  = '0;
    w_sel_be    = '0;
    w_sel_read  = 1'b0;
    w_sel_write = 1'b0;
    w_sel_wdata = '0;
    w_sel_begin = 1'b0;
    w_sel_bcnt  = '0;
    for (int m = 0; m < MASTER_NUM; m++) begin
      if (ID_W'(m) == w_sel) begin
        w_sel_addr  = i_s_address[m];
        w_sel_be    = i_s_byte_en[m];
        w_sel_read  = i_s_read[m];
        w_sel_write = i_s_write[m];
        w_sel_wdata = i_s_write_data[m];
        w_sel_begin = i_s_begin_burst_transfer[m];
        w_sel_bcnt  = i_s_burst_count[m];
      end
    end
  end

  // Reads are held off while the ID FIFO is full; writes never need an ID slot.
  assign o_m_address              = w_fwd_en ? w_sel_addr  : '0;
  assign o_m_byte_en              = w_fwd_en ? w_sel_be    : '0;
  assign o_m_write_data           = w_fwd_en ? w_sel_wdata : '0;
  assign o_m_begin_burst_transfer = w_fwd_en && w_sel_begin;
  assign o_m_burst_count          = w_fwd_en ? w_sel_bcnt  : '0;
  assign o_m_read                 = w_fwd_en && w_sel_read && !w_fifo_full;
  assign o_m_write                = w_fwd_en && w_sel_write;

  assign w_grant_rdy   = w_fwd_en && i_m_request_ready && !(w_sel_read && w_fifo_full);
  assign w_accept      = (o_m_read || o_m_write) && i_m_request_ready;
  assign w_burst_start = w_sel_begin && (w_sel_bcnt != '0);

  always_comb begin
    w_head_rdy          = 1'b0;
    o_s_request_ready   = '0;
    o_s_read_data_valid = '0;
    for (int m = 0; m < MASTER_NUM; m++) begin
      if (ID_W'(m) == w_sel) begin
        o_s_request_ready[m] = w_grant_rdy;
      end
      if (ID_W'(m) == w_head_id) begin
        o_s_read_data_valid[m] = !rest && i_m_read_data_valid && !w_fifo_empty;
        w_head_rdy             = i_s_resp_ready[m];
      end
    end
  end

  // With no outstanding ID the response is orphaned, so it is drained and dropped.
  assign o_s_read_data  = i_m_read_data;
  assign o_m_resp_ready = !rest && (w_fifo_empty ? 1'b1 : w_head_rdy);
  assign w_push         = w_accept && o_m_read;
  assign w_pop          = i_m_read_data_valid && o_m_resp_ready && !w_fifo_empty;

  avl_bus_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rest    (rest),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_sel),
    .o_dout  (w_head_id),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_beats_next = r_beats_left;
    case (r_state)
      ARB_IDLE: begin
        if (w_accept && w_burst_start) begin
          w_state_next = ARB_BURST;
          w_owner_next = w_sel;
          w_beats_next = w_sel_bcnt;
        end
      end
      ARB_BURST: begin
        if (w_accept) begin
          w_beats_next = r_beats_left - BEAT_ONE;
          if (r_beats_left == BEAT_ONE) begin
            w_state_next = ARB_IDLE;
          end
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_state      <= ARB_IDLE;
      r_owner      <= '0;
      r_beats_left <= '0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_beats_left <= w_beats_next;
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_resp_err <= 1'b0;
    end else if (i_m_read_data_valid && w_fifo_empty) begin
      r_resp_err <= 1'b1;
    end
  end

  assign resp_err = r_resp_err;

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// Self-checking bench for avl_bus_arbiter: arbitration vector table plus
// scripted burst, FIFO-full, routing and reset sequences with a response scoreboard.
module tb_avl_bus_arbiter;
  import avl_bus_arbiter_pkg::*;

  localparam int NM = 4;

  logic clk = 1'b0;
  logic rest;

  logic [NM-1:0][AVL_ADDR_W-1:0]  sAddr;
  logic [NM-1:0][AVL_BE_W-1:0]    sBe;
  logic [NM-1:0]                  sRead;
  logic [NM-1:0]                  sWrite;
  logic [NM-1:0][AVL_DATA_W-1:0]  sWdata;
  logic [NM-1:0]                  sBegin;
  logic [NM-1:0][AVL_BURST_W-1:0] sBcnt;
  logic [NM-1:0]                  sRespReady;
  logic [NM-1:0]                  sReqReady;
  logic [NM-1:0]                  sRvalid;
  logic [AVL_DATA_W-1:0]          sRdata;
  logic [AVL_ADDR_W-1:0]          mAddr;
  logic [AVL_BE_W-1:0]            mBe;
  logic                           mRead;
  logic                           mWrite;
  logic [AVL_DATA_W-1:0]          mWdata;
  logic                           mBegin;
  logic [AVL_BURST_W-1:0]         mBcnt;
  logic                           mReady;
  logic [AVL_DATA_W-1:0]          mRdata;
  logic                           mRvalid;
  logic                           mRespReady;
  logic                           respErr;

  int testsRun    = 0;
  int testsFailed = 0;
  int sbQ[$];

  typedef struct {
    logic [NM-1:0] wrMask;
    logic          ready;
    int            expFixed;
    int            expRr;
  } arbVec_t;

  arbVec_t vecs[12];

  always #5 clk = ~clk;

  avl_bus_arbiter #(
    .MASTER_NUM      (NM),
    .RESP_FIFO_DEPTH (8)
  ) dut (
    .clk                      (clk),
    .rest                     (rest),
    .i_s_address              (sAddr),
    .i_s_byte_en              (sBe),
    .i_s_read                 (sRead),
    .i_s_write                (sWrite),
    .i_s_write_data           (sWdata),
    .i_s_begin_burst_transfer (sBegin),
    .i_s_burst_count          (sBcnt),
    .o_s_request_ready        (sReqReady),
    .o_s_read_data            (sRdata),
    .o_s_read_data_valid      (sRvalid),
    .i_s_resp_ready           (sRespReady),
    .o_m_address              (mAddr),
    .o_m_byte_en              (mBe),
    .o_m_read                 (mRead),
    .o_m_write                (mWrite),
    .o_m_write_data           (mWdata),
    .o_m_begin_burst_transfer (mBegin),
    .o_m_burst_count          (mBcnt),
    .i_m_request_ready        (mReady),
    .i_m_read_data            (mRdata),
    .i_m_read_data_valid      (mRvalid),
    .o_m_resp_ready           (mRespReady),
    .resp_err                 (respErr)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    for (int m = 0; m < NM; m++) begin
      sAddr[m]  = 32'h1000 + 32'(m) * 32'h100;
      sWdata[m] = 32'hD000_0000 | 32'(m);
      sBe[m]    = '1;
      sBcnt[m]  = '0;
    end
    sRead      = '0;
    sWrite     = '0;
    sBegin     = '0;
    sRespReady = '1;
    mReady     = 1'b1;
    mRdata     = '0;
    mRvalid    = 1'b0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rest = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    rest = 1'b0;
  endtask

  // Response scoreboard: IDs queued on read handshakes, checked in order on responses.
  always @(negedge clk) begin
    logic [NM-1:0] expMask;
    logic          expRdy;
    if (rest) begin
      sbQ.delete();
    end else begin
      if (mRvalid) begin
        expMask = (sbQ.size() != 0) ? (NM'(1) << sbQ[0]) : '0;
        expRdy  = (sbQ.size() != 0) ? sRespReady[sbQ[0]] : 1'b1;
        checkOutput("sb_rvalid", sRvalid, expMask);
        checkOutput("sb_resp_ready", mRespReady, expRdy);
        checkOutput("sb_rdata", sRdata, mRdata);
        if (sbQ.size() != 0 && expRdy) void'(sbQ.pop_front());
      end
      for (int m = 0; m < NM; m++) begin
        if (sReqReady[m] && sRead[m]) sbQ.push_back(m);
      end
    end
  end

  initial begin
    vecs[0]  = '{4'b0101, 1'b1, 0, 0};
    vecs[1]  = '{4'b0101, 1'b1, 0, 2};
    vecs[2]  = '{4'b0101, 1'b1, 0, 0};
    vecs[3]  = '{4'b0101, 1'b1, 0, 2};
    vecs[4]  = '{4'b1111, 1'b0, 0, 3};
    vecs[5]  = '{4'b1111, 1'b1, 0, 3};
    vecs[6]  = '{4'b1110, 1'b1, 1, 1};
    vecs[7]  = '{4'b1010, 1'b1, 1, 3};
    vecs[8]  = '{4'b0000, 1'b1, -1, -1};
    vecs[9]  = '{4'b1000, 1'b1, 3, 3};
    vecs[10] = '{4'b1111, 1'b1, 0, 0};
    vecs[11] = '{4'b1111, 1'b1, 0, 1};

    // Reset values, with masters and slave already active.
    rest = 1'b1;
    clearInputs();
    sRead[0]  = 1'b1;
    sWrite[2] = 1'b1;
    mRvalid   = 1'b1;
    #3;
    checkOutput("rst_m_read", mRead, 1'b0);
    checkOutput("rst_m_write", mWrite, 1'b0);
    checkOutput("rst_m_addr", mAddr, 32'h0);
    checkOutput("rst_req_ready", sReqReady, 4'b0000);
    checkOutput("rst_rvalid", sRvalid, 4'b0000);
    checkOutput("rst_resp_err", respErr, 1'b0);
    doReset();

    // Arbitration table: single writes, no bursts.
    for (int i = 0; i < 12; i++) begin
      int               expId;
      logic [31:0]      expAddr;
      logic [NM-1:0]    expRdy;
      applyStimulus();
      sWrite = vecs[i].wrMask;
      mReady = vecs[i].ready;
`ifdef AVL_ARB_ROUND_ROBIN_EN
      expId = vecs[i].expRr;
`else
      expId = vecs[i].expFixed;
`endif
      expAddr = (expId < 0) ? 32'h0 : 32'h1000 + 32'(expId) * 32'h100;
      expRdy  = (expId >= 0 && vecs[i].ready) ? (NM'(1) << expId) : '0;
      #2;
      checkOutput($sformatf("arb%0d_addr", i), mAddr, expAddr);
      checkOutput($sformatf("arb%0d_req_ready", i), sReqReady, expRdy);
      checkOutput($sformatf("arb%0d_m_write", i), mWrite, expId >= 0);
    end

    // All masters requesting continuously.
    doReset();
    for (int k = 0; k < 4; k++) begin
      int expId;
      applyStimulus();
      sWrite = 4'b1111;
`ifdef AVL_ARB_ROUND_ROBIN_EN
      expId = k;
`else
      expId = 0;
`endif
      #2;
      checkOutput($sformatf("all_req%0d", k), sReqReady, NM'(1) << expId);
    end

    // Burst lock: master 1 reads 4 beats while master 3 waits to write.
    doReset();
    applyStimulus();
    sRead[1]  = 1'b1;
    sBegin[1] = 1'b1;
    sBcnt[1]  = 4'd3;
    sAddr[1]  = 32'h2000;
    sWrite[3] = 1'b1;
    #2;
    checkOutput("bst0_addr", mAddr, 32'h2000);
    checkOutput("bst0_bcnt", mBcnt, 4'd3);
    checkOutput("bst0_begin", mBegin, 1'b1);
    checkOutput("bst0_ready", sReqReady, 4'b0010);
    applyStimulus();
    sAddr[1]  = 32'h2004;
    sBegin[1] = 1'b0;
    #2;
    checkOutput("bst1_addr", mAddr, 32'h2004);
    checkOutput("bst1_ready", sReqReady, 4'b0010);
    applyStimulus();
    sAddr[1] = 32'h2008;
    mReady   = 1'b0;
    #2;
    checkOutput("bst_stall_addr", mAddr, 32'h2008);
    checkOutput("bst_stall_ready", sReqReady, 4'b0000);
    applyStimulus();
    mReady = 1'b1;
    #2;
    checkOutput("bst2_ready", sReqReady, 4'b0010);
    applyStimulus();
    sRead[1] = 1'b0;
    #2;
    checkOutput("bst_drop_read", mRead, 1'b0);
    checkOutput("bst_drop_write", mWrite, 1'b0);
    applyStimulus();
    sRead[1] = 1'b1;
    sAddr[1] = 32'h200C;
    #2;
    checkOutput("bst3_addr", mAddr, 32'h200C);
    checkOutput("bst3_ready", sReqReady, 4'b0010);
    applyStimulus();
    sRead[1] = 1'b0;
    #2;
    checkOutput("bst_next_ready", sReqReady, 4'b1000);
    checkOutput("bst_next_addr", mAddr, 32'h1300);
    applyStimulus();
    sWrite[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mRvalid = 1'b1;
      mRdata  = 32'hC0DE_0000 + 32'(k);
      applyStimulus();
    end
    mRvalid = 1'b0;

    // FIFO full: eight reads outstanding from master 0.
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      sRead[0] = 1'b1;
      #2;
      checkOutput($sformatf("fill%0d_ready", k), sReqReady, 4'b0001);
    end
    applyStimulus();
    #2;
    checkOutput("full_ready", sReqReady, 4'b0000);
    checkOutput("full_m_read", mRead, 1'b0);
    applyStimulus();
    sRead[0]  = 1'b0;
    sWrite[1] = 1'b1;
    #2;
    checkOutput("full_wr1_ready", sReqReady, 4'b0010);
    checkOutput("full_wr1_write", mWrite, 1'b1);
    applyStimulus();
    sWrite[1] = 1'b0;
    sWrite[0] = 1'b1;
    #2;
    checkOutput("full_wr0_ready", sReqReady, 4'b0001);
    applyStimulus();
    sWrite[0] = 1'b0;
    sRead[0]  = 1'b1;
    mRvalid   = 1'b1;
    mRdata    = 32'h5555_0000;
    #2;
    checkOutput("full_pop_ready", sReqReady, 4'b0000);
    applyStimulus();
    mRvalid = 1'b0;
    #2;
    checkOutput("after_pop_ready", sReqReady, 4'b0001);
    checkOutput("after_pop_read", mRead, 1'b1);
    applyStimulus();
    sRead[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mRvalid = 1'b1;
      mRdata  = 32'h5555_0001 + 32'(k);
      applyStimulus();
    end
    mRvalid = 1'b0;

    // In-order routing: master 3 then master 1, master 1 briefly not ready.
    doReset();
    applyStimulus();
    sRead[3] = 1'b1;
    #2;
    checkOutput("rt_rd3_ready", sReqReady, 4'b1000);
    applyStimulus();
    sRead[3] = 1'b0;
    sRead[1] = 1'b1;
    #2;
    checkOutput("rt_rd1_ready", sReqReady, 4'b0010);
    applyStimulus();
    sRead[1]   = 1'b0;
    sRespReady = 4'b1000;
    mRvalid    = 1'b1;
    mRdata     = 32'hAAAA_0003;
    #2;
    checkOutput("rt_rsp3_valid", sRvalid, 4'b1000);
    checkOutput("rt_rsp3_rdata", sRdata, 32'hAAAA_0003);
    for (int k = 0; k < 2; k++) begin
      applyStimulus();
      mRdata = 32'hBBBB_0001;
      #2;
      checkOutput($sformatf("rt_hold%0d_resp_ready", k), mRespReady, 1'b0);
      checkOutput($sformatf("rt_hold%0d_valid", k), sRvalid, 4'b0010);
    end
    applyStimulus();
    sRespReady = 4'b1010;
    #2;
    checkOutput("rt_rsp1_resp_ready", mRespReady, 1'b1);
    applyStimulus();
    mRvalid = 1'b0;
    #2;
    checkOutput("rt_idle_valid", sRvalid, 4'b0000);

    // Reset during beat 2 of a write burst, then an orphaned response.
    doReset();
    applyStimulus();
    sWrite[2] = 1'b1;
    sBegin[2] = 1'b1;
    sBcnt[2]  = 4'd3;
    sAddr[2]  = 32'h3000;
    #2;
    checkOutput("rb0_ready", sReqReady, 4'b0100);
    applyStimulus();
    sBegin[2] = 1'b0;
    sAddr[2]  = 32'h3004;
    #2;
    checkOutput("rb1_ready", sReqReady, 4'b0100);
    applyStimulus();
    sAddr[2] = 32'h3008;
    #2;
    rest = 1'b1;
    #1;
    checkOutput("rb_rst_write", mWrite, 1'b0);
    checkOutput("rb_rst_addr", mAddr, 32'h0);
    checkOutput("rb_rst_ready", sReqReady, 4'b0000);
    checkOutput("rb_rst_resp_ready", mRespReady, 1'b0);
    @(posedge clk);
    #1;
    clearInputs();
    rest = 1'b0;
    applyStimulus();
    sWrite[0] = 1'b1;
    #2;
    checkOutput("rb_unlock_ready", sReqReady, 4'b0001);
    checkOutput("rb_unlock_addr", mAddr, 32'h1000);
    applyStimulus();
    sWrite[0] = 1'b0;
    mRvalid   = 1'b1;
    mRdata    = 32'hDEAD_BEEF;
    #2;
    checkOutput("orphan_resp_ready", mRespReady, 1'b1);
    checkOutput("orphan_err_before", respErr, 1'b0);
    applyStimulus();
    mRvalid = 1'b0;
    #2;
    checkOutput("orphan_err_set", respErr, 1'b1);
    applyStimulus();
    #2;
    checkOutput("orphan_err_sticky", respErr, 1'b1);

    checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/avl_bus_arbiter.md
# avl_bus_arbiter

Shares one downstream Avalon-style slave port among `MASTER_NUM` upstream masters on the `i_avl_bus` protocol. Arbitration is round-robin and locks the grant for the whole burst. Read responses are returned in order and routed back to the requesting master through an internal master-ID FIFO. Sits between bus masters (CPU I/D ports, DMA) and a single slave such as the SDRAM controller. It is the block `avl_bus_master_sim_model` instances drive in the shared-slave benches.

## Interface
- `MASTER_NUM`, 4: number of upstream masters (2..16).
- `RESP_FIFO_DEPTH`, 8: outstanding read beats tracked (power of two).
- `clk` in 1: clock, rising edge.
- `rest` in 1: asynchronous, active-high reset.
- `avl_s[MASTER_NUM-1:0]` i_avl_bus.slave: upstream ports, one per master; index = master ID.
- `avl_m` i_avl_bus.master: downstream port to the shared slave.
- `resp_err` out 1: sticky flag; a read response arrived with the ID FIFO empty.

## Operation
- States: `ARB_IDLE`, `ARB_BURST`.
- A master requests when `read|write` is high.
- ARB_IDLE:
  - Winner = first requester at or after `rr_ptr`, searching upward modulo `MASTER_NUM`.
  - The winner's address, byte_en, read, write, write_data, begin_burst_transfer and burst_count are forwarded combinationally to `avl_m`.
  - `avl_m.request_ready` is returned to the winner only; all others see `request_ready=0`.
- Beat accepted = forwarded (read|write) && `avl_m.request_ready`.
- Accepted beat with `begin_burst_transfer && burst_count!=0`:
  - `owner` <= winner, `beats_left` <= burst_count, go to ARB_BURST.
  - A burst is burst_count+1 beats total.
- ARB_BURST:
  - Only `owner` is forwarded; no re-arbitration.
  - Each accepted beat decrements `beats_left`.
  - The accepted beat with `beats_left==1` returns to ARB_IDLE.
- `rr_ptr` <= (last master + 1) mod `MASTER_NUM` when a transaction ends: a single beat is accepted, or the last burst beat is accepted.
- Read ID FIFO:
  - Push the master ID on every accepted read beat.
  - Pop on `avl_m.read_data_valid && avl_m.resp_ready`.
- FIFO full:
  - Read beats are gated: `avl_m.read` is forced to 0 and the master sees `request_ready=0`.
  - Writes still pass.
  - A pop in the same cycle does not unblock the push; the push is retried next cycle.
- Response routing:
  - `read_data` is broadcast to all masters.
  - `read_data_valid` goes only to `avl_s[head_id]`.
  - `avl_m.resp_ready = avl_s[head_id].resp_ready`.
- FIFO empty with `read_data_valid=1`: drive `avl_m.resp_ready=1` to drain the beat, discard it, set `resp_err`.

## Timing
- Request path: combinational, zero added latency; a beat is issued in the same cycle as the master presents it.
- Response path: combinational from `avl_m` to the master; the FIFO head ID is registered.
- Reset values:
  - state=ARB_IDLE, rr_ptr=0, beats_left=0, owner=0.
  - FIFO empty, resp_err=0.
  - All `avl_m` command outputs 0.
  - All upstream request_ready and read_data_valid outputs 0.
- Reset mid-burst or with outstanding reads: all state is discarded. Responses arriving after reset hit an empty FIFO and set `resp_err`.
- A master that drops read/write mid-burst simply stalls the burst; the lock is held until `beats_left` reaches 0.

## Configuration
- `AVL_ARB_ROUND_ROBIN_EN` defined: rotating priority as above.
- Undefined: fixed priority, lowest index wins; `rr_ptr` logic is removed; burst lock and FIFO are unchanged.

## Structure
- Add to package `avl_bus_type`:
  - `avl_arb_state_t` (ARB_IDLE, ARB_BURST).
  - `AVL_ARB_ID_W = $clog2(MASTER_NUM max 16)` = 4.
- Burst length bound: existing `ALV_BURST_MAX_COUNT`.
- Sub-module `avl_bus_id_fifo`:
  - Synchronous FIFO with parameters width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - Reset: same `rest`.

## Test plan
- Masters 0 and 2 issue single writes every cycle, slave always ready: grants alternate 0,2,0,2; no master starves.
- Master 1 issues a read burst with burst_count=3 while master 3 requests: master 1 gets 4 consecutive beats at addr A..A+12, then master 3 is granted.
- 8 reads from master 0 are accepted and the slave withholds responses: the 9th read sees request_ready=0; a write from master 1 still passes. After one response the 9th read is accepted on the following cycle.
- Reads from masters 3 then 1 return data 0xAAAA_0003 then 0xBBBB_0001: read_data_valid asserts only to master 3, then to master 1. With master 1 resp_ready=0 for 2 cycles, `avl_m.resp_ready` stays 0 for those cycles.
- Assert `rest` during beat 2 of a 4-beat burst: all outputs return to reset values. A subsequent unsolicited response sets resp_err=1 and is drained.
- Build without `AVL_ARB_ROUND_ROBIN_EN`, all masters requesting continuously: master 0 is granted every transaction.
